// File: rtl/stream_push2.sv
// rtl/stream_push2.sv - emits two latched operands, then forwards an upstream stream
//
// Ports:
//   clk, nrst                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready       operand handshake; dIn0, dIn1 are the two head elements
//   sIn, sIn_valid, sIn_last  upstream stream, consumed via sIn_ready
//   sOut, sOut_valid,         output stream: dIn0, dIn1, then every upstream element
//   sOut_last, sOut_ready
//   out_valid                 registered one-cycle pulse after the final beat transfers
//
// Optional feature macro: STREAM_PUSH2_SKID_EN
//   undefined: PASS forwards sIn to sOut combinationally (zero latency)
//   defined:   all outputs registered, two-entry skid buffer in PASS (one cycle latency)

module stream_push2 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dIn0,
    input  logic [N-1:0] dIn1,
    input  logic [N-1:0] sIn,
    input  logic         sIn_valid,
    input  logic         sIn_last,
    output logic         sIn_ready,
    output logic [N-1:0] sOut,
    output logic         sOut_valid,
    output logic         sOut_last,
    input  logic         sOut_ready,
    output logic         out_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HEAD0 = 2'd1;
    localparam logic [1:0] S_HEAD1 = 2'd2;
    localparam logic [1:0] S_PASS  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] r1_q;
    logic         out_valid_q, out_valid_d;

    assign out_valid = out_valid_q;

`ifdef STREAM_PUSH2_SKID_EN
    // Output register (so_*) plus one skid entry (sk_*). The output register also
    // carries the first head, so it plays the role of r0 in this build.
    logic [N-1:0] so_data_q, so_data_d, sk_data_q, sk_data_d;
    logic         so_valid_q, so_valid_d, so_last_q, so_last_d;
    logic         sk_valid_q, sk_valid_d, sk_last_q, sk_last_d;
    logic         seen_q, seen_d;   // last upstream beat already accepted
    logic         out_xfer, in_xfer;

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        so_data_d   = so_data_q;
        so_valid_d  = so_valid_q;
        so_last_d   = so_last_q;
        sk_data_d   = sk_data_q;
        sk_valid_d  = sk_valid_q;
        sk_last_d   = sk_last_q;
        seen_d      = seen_q;
        in_ready    = (state_q == S_IDLE);
        // Occupancy only: never looks at sOut_ready. Stops after the last beat so
        // the next stream's data stays upstream.
        sIn_ready   = (state_q == S_PASS) && !sk_valid_q && !seen_q;
        out_xfer    = so_valid_q && sOut_ready;
        in_xfer     = sIn_valid && sIn_ready;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d    = S_HEAD0;
                    so_data_d  = dIn0;
                    so_valid_d = 1'b1;
                    so_last_d  = 1'b0;
                    seen_d     = 1'b0;
                end
            end
            S_HEAD0: begin
                if (out_xfer) begin
                    state_d   = S_HEAD1;
                    so_data_d = r1_q;
                end
            end
            S_HEAD1: begin
                if (out_xfer) begin
                    state_d    = S_PASS;
                    so_valid_d = 1'b0;
                end
            end
            default: begin
                if (in_xfer && sIn_last) begin
                    seen_d = 1'b1;
                end
                if (!so_valid_q || out_xfer) begin
                    if (sk_valid_q) begin
                        so_data_d  = sk_data_q;
                        so_last_d  = sk_last_q;
                        so_valid_d = 1'b1;
                        sk_valid_d = 1'b0;
                    end else if (in_xfer) begin
                        so_data_d  = sIn;
                        so_last_d  = sIn_last;
                        so_valid_d = 1'b1;
                    end else begin
                        so_valid_d = 1'b0;
                    end
                end else if (in_xfer) begin
                    sk_data_d  = sIn;
                    sk_last_d  = sIn_last;
                    sk_valid_d = 1'b1;
                end
                // The final beat can only be in the output register with the skid
                // entry already drained, so the buffer is empty on exit.
                if (out_xfer && so_last_q) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                end
            end
        endcase
    end

    assign sOut       = so_data_q;
    assign sOut_valid = so_valid_q;
    assign sOut_last  = so_last_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            r1_q        <= '0;
            out_valid_q <= 1'b0;
            so_data_q   <= '0;
            so_valid_q  <= 1'b0;
            so_last_q   <= 1'b0;
            sk_data_q   <= '0;
            sk_valid_q  <= 1'b0;
            sk_last_q   <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            so_data_q   <= so_data_d;
            so_valid_q  <= so_valid_d;
            so_last_q   <= so_last_d;
            sk_data_q   <= sk_data_d;
            sk_valid_q  <= sk_valid_d;
            sk_last_q   <= sk_last_d;
            seen_q      <= seen_d;
            if (in_valid && in_ready) begin
                r1_q <= dIn1;
            end
        end
    end
`else
    logic [N-1:0] r0_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        in_ready    = 1'b0;
        sIn_ready   = 1'b0;
        sOut        = '0;
        sOut_valid  = 1'b0;
        sOut_last   = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_HEAD0;
                end
            end
            S_HEAD0: begin
                sOut       = r0_q;
                sOut_valid = 1'b1;
                if (sOut_ready) begin
                    state_d = S_HEAD1;
                end
            end
            S_HEAD1: begin
                sOut       = r1_q;
                sOut_valid = 1'b1;
                if (sOut_ready) begin
                    state_d = S_PASS;
                end
            end
            default: begin
                sOut       = sIn;
                sOut_valid = sIn_valid;
                sOut_last  = sIn_last;
                sIn_ready  = sOut_ready;
                if (sIn_valid && sOut_ready && sIn_last) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            r0_q        <= '0;
            r1_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (in_valid && in_ready) begin
                r0_q <= dIn0;
                r1_q <= dIn1;
            end
        end
    end
`endif

endmodule
